// File: rtl/vga_cursor_overlay.sv
// Text-mode hardware cursor overlay: inverts the pixel colour inside the
// cursor cell, with frame-synchronous register updates and blinking.
module vga_cursor_overlay #(
    parameter int TEXT_COLS   = 80,
    parameter int TEXT_ROWS   = 25,
    parameter int BORDER_ROWS = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  pix_r,
    input  logic [3:0]  pix_g,
    input  logic [3:0]  pix_b,
    input  logic        pix_hsync,
    input  logic        pix_vsync,
    input  logic [9:0]  pix_row,
    input  logic [9:0]  pix_col,
    input  logic        reg_wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [10:0] reg_wr_data,
    output logic [10:0] reg_rd_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    localparam logic [9:0]  LP_TOP   = 10'(BORDER_ROWS);
    localparam logic [9:0]  LP_BOT   = 10'(BORDER_ROWS + 16 * TEXT_ROWS);
    localparam logic [9:0]  LP_RIGHT = 10'(8 * TEXT_COLS);
    localparam logic [15:0] LP_COLS  = 16'(TEXT_COLS);

    logic        r_vsync_d;
    logic [4:0]  r_blink;

    logic [10:0] r_sh_pos;
    logic [2:0]  r_sh_start;
    logic [2:0]  r_sh_end;
    logic        r_sh_en;
    logic        r_sh_boff;

    logic [10:0] r_act_pos;
    logic [2:0]  r_act_start;
    logic [2:0]  r_act_end;
    logic        r_act_en;
    logic        r_act_boff;

    logic        w_frame;
    logic [9:0]  w_rel;
    logic [15:0] w_cell;
    logic [2:0]  w_scan;
    logic        w_in_text;
    logic        w_visible;
    logic        w_hit;
    logic        w_unused_bits;

    assign w_frame = r_vsync_d & ~pix_vsync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync_d  <= 1'b1;
            r_blink    <= '0;
            r_sh_pos   <= '0;
            r_sh_start <= 3'd6;
            r_sh_end   <= 3'd7;
            r_sh_en    <= 1'b1;
            r_sh_boff  <= 1'b0;
        end else begin
            r_vsync_d <= pix_vsync;
            if (w_frame)
                r_blink <= r_blink + 5'd1;
            if (reg_wr_en) begin
                case (reg_sel)
                    2'd0: r_sh_pos <= reg_wr_data;
                    2'd1: begin
                        r_sh_start <= reg_wr_data[2:0];
                        r_sh_end   <= reg_wr_data[5:3];
                    end
                    2'd2: begin
                        r_sh_en   <= reg_wr_data[0];
                        r_sh_boff <= reg_wr_data[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Non-blocking copy means a same-edge write lands one frame later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_act_pos   <= '0;
            r_act_start <= 3'd6;
            r_act_end   <= 3'd7;
            r_act_en    <= 1'b1;
            r_act_boff  <= 1'b0;
        end else if (w_frame) begin
            r_act_pos   <= r_sh_pos;
            r_act_start <= r_sh_start;
            r_act_end   <= r_sh_end;
            r_act_en    <= r_sh_en;
            r_act_boff  <= r_sh_boff;
        end
    end

    always_comb begin
        reg_rd_data = '0;
        case (reg_sel)
            2'd0:    reg_rd_data = r_sh_pos;
            2'd1:    reg_rd_data = {5'b0, r_sh_end, r_sh_start};
            2'd2:    reg_rd_data = {9'b0, r_sh_boff, r_sh_en};
            default: reg_rd_data = '0;
        endcase
    end

    assign w_rel     = pix_row - LP_TOP;
    assign w_cell    = {10'b0, w_rel[9:4]} * LP_COLS + {9'b0, pix_col[9:3]};
    assign w_scan    = w_rel[3:1];
    assign w_in_text = (pix_row >= LP_TOP) && (pix_row < LP_BOT)
                     && (pix_col < LP_RIGHT);
    assign w_visible = ~r_blink[4] | r_act_boff;

    // Out-of-range POS cannot match since in-text cells stay below the limit.
    assign w_hit = w_in_text && r_act_en && w_visible
                 && (w_cell == {5'b0, r_act_pos})
                 && (r_act_start <= w_scan) && (w_scan <= r_act_end);

    assign w_unused_bits = &{1'b0, w_rel[0], pix_col[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            vga_r     <= w_hit ? ~pix_r : pix_r;
            vga_g     <= w_hit ? ~pix_g : pix_g;
            vga_b     <= w_hit ? ~pix_b : pix_b;
            vga_hsync <= pix_hsync;
            vga_vsync <= pix_vsync;
        end
    end

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Scoreboard bench for vga_cursor_overlay: driver queues expected pixels,
// monitor compares the registered output one cycle later.
module tb_vga_cursor_overlay;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  pix_r, pix_g, pix_b;
    logic        pix_hsync, pix_vsync;
    logic [9:0]  pix_row, pix_col;
    logic        reg_wr_en;
    logic [1:0]  reg_sel;
    logic [10:0] reg_wr_data;
    logic [10:0] reg_rd_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync;

    always #5 clk = ~clk;

    vga_cursor_overlay #(
        .TEXT_COLS(80), .TEXT_ROWS(25), .BORDER_ROWS(40)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_hsync(pix_hsync), .pix_vsync(pix_vsync),
        .pix_row(pix_row), .pix_col(pix_col),
        .reg_wr_en(reg_wr_en), .reg_sel(reg_sel),
        .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
    );

    typedef struct {
        int         id;
        logic [3:0] r, g, b;
        logic       hs, vs;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   id_cnt   = 0;

    logic [10:0] s_pos, a_pos;
    logic [2:0]  s_st, s_end, a_st, a_end;
    logic        s_en, s_boff, a_en, a_boff;
    logic [4:0]  m_cnt;
    logic        m_prev_vs;

    task automatic m_reset();
        s_pos = 0; s_st = 6; s_end = 7; s_en = 1; s_boff = 0;
        a_pos = 0; a_st = 6; a_end = 7; a_en = 1; a_boff = 0;
        m_cnt = 0; m_prev_vs = 1;
    endtask

    // Cursor rectangle in screen coordinates for the active settings.
    function automatic logic hit(input logic [9:0] row, input logic [9:0] col);
        int top, left;
        if (!a_en) return 1'b0;
        if (m_cnt[4] && !a_boff) return 1'b0;
        if (a_pos >= 11'd2000) return 1'b0;
        top  = 40 + 16 * (int'(a_pos) / 80);
        left = 8 * (int'(a_pos) % 80);
        return (int'(row) >= top + 2 * int'(a_st))
            && (int'(row) <= top + 2 * int'(a_end) + 1)
            && (int'(col) >= left) && (int'(col) < left + 8);
    endfunction

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input logic [9:0] row, input logic [9:0] col,
                         input logic [3:0] c, input logic hs,
                         input logic vs, input logic wr,
                         input logic [1:0] sel, input logic [10:0] d);
        exp_t e;
        logic h;
        @(posedge clk);
        #1;
        pix_row = row; pix_col = col;
        pix_r = c; pix_g = c ^ 4'h5; pix_b = c ^ 4'hA;
        pix_hsync = hs; pix_vsync = vs;
        reg_wr_en = wr; reg_sel = sel; reg_wr_data = d;
        h = hit(row, col);
        e.id = id_cnt++;
        e.r  = h ? ~pix_r : pix_r;
        e.g  = h ? ~pix_g : pix_g;
        e.b  = h ? ~pix_b : pix_b;
        e.hs = hs;
        e.vs = vs;
        q.push_back(e);
        if (m_prev_vs && !vs) begin
            a_pos = s_pos; a_st = s_st; a_end = s_end;
            a_en = s_en; a_boff = s_boff;
            m_cnt = m_cnt + 5'd1;
        end
        m_prev_vs = vs;
        if (wr) begin
            case (sel)
                2'd0: s_pos = d;
                2'd1: begin s_st = d[2:0]; s_end = d[5:3]; end
                2'd2: begin s_en = d[0]; s_boff = d[1]; end
                default: ;
            endcase
        end
    endtask

    task automatic px(input int row, input int col, input logic [3:0] c);
        drive(10'(row), 10'(col), c, 1'b1, 1'b1, 1'b0, 2'd0, 11'd0);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [10:0] d);
        drive(10'd0, 10'd700, 4'h3, 1'b1, 1'b1, 1'b1, sel, d);
    endtask

    task automatic frame(input logic w, input logic [1:0] sel,
                         input logic [10:0] d);
        drive(10'd0, 10'd700, 4'h3, 1'b1, 1'b1, 1'b0, 2'd0, 11'd0);
        drive(10'd0, 10'd700, 4'h3, 1'b0, 1'b0, w, sel, d);
        drive(10'd0, 10'd700, 4'h3, 1'b1, 1'b1, 1'b0, 2'd0, 11'd0);
    endtask

    task automatic chk_rd(input string name, input logic [1:0] sel,
                          input logic [10:0] want);
        @(posedge clk);
        #1;
        reg_wr_en = 1'b0;
        reg_sel   = sel;
        #1;
        chk(name, {5'b0, reg_rd_data}, {5'b0, want});
    endtask

    initial begin : monitor
        exp_t cur;
        bit   have;
        forever begin
            @(posedge clk);
            have = 0;
            if (q.size() > 0) begin
                cur  = q.pop_front();
                have = 1;
            end
            @(negedge clk);
            if (have) begin
                checks++;
                if (vga_r !== cur.r || vga_g !== cur.g || vga_b !== cur.b ||
                    vga_hsync !== cur.hs || vga_vsync !== cur.vs) begin
                    failures++;
                    $display("FAIL pix id=%0d got r%h g%h b%h hs%b vs%b want r%h g%h b%h hs%b vs%b",
                             cur.id, vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
                             cur.r, cur.g, cur.b, cur.hs, cur.vs);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset_n = 1'b0;
        m_reset();
        pix_r = 4'h7; pix_g = 4'h7; pix_b = 4'h7;
        pix_hsync = 1'b0; pix_vsync = 1'b0;
        pix_row = 10'd52; pix_col = 10'd0;
        reg_wr_en = 1'b1; reg_sel = 2'd0; reg_wr_data = 11'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_r", {12'b0, vga_r}, 16'h0);
        chk("rst_g", {12'b0, vga_g}, 16'h0);
        chk("rst_b", {12'b0, vga_b}, 16'h0);
        chk("rst_hs", {15'b0, vga_hsync}, 16'h1);
        chk("rst_vs", {15'b0, vga_vsync}, 16'h1);
        reg_wr_en = 1'b0;
        pix_vsync = 1'b1; pix_hsync = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        chk_rd("rd_pos_rst", 2'd0, 11'd0);
        chk_rd("rd_shape_rst", 2'd1, 11'h03E);
        chk_rd("rd_ctrl_rst", 2'd2, 11'd1);
        chk_rd("rd_rsv", 2'd3, 11'd0);

        for (int r = 40; r <= 55; r++)
            for (int c = 0; c <= 8; c++)
                px(r, c, 4'h3);

        wr(2'd0, 11'd81);
        chk_rd("rd_pos81", 2'd0, 11'd81);
        px(52, 0, 4'h3);
        px(68, 8, 4'h3);
        frame(1'b0, 2'd0, 11'd0);
        px(52, 0, 4'h3);
        for (int r = 56; r <= 71; r++) begin
            px(r, 8, 4'h3);
            px(r, 15, 4'h3);
            px(r, 16, 4'h3);
        end

        frame(1'b1, 2'd0, 11'd0);
        px(68, 8, 4'h3);
        px(52, 0, 4'h3);
        frame(1'b0, 2'd0, 11'd0);
        px(52, 0, 4'h3);
        px(68, 8, 4'h3);

        for (int f = 0; f < 64; f++) begin
            frame(1'b0, 2'd0, 11'd0);
            px(52, 0, 4'h3);
            px(53, 0, 4'h9);
        end

        wr(2'd2, 11'd3);
        frame(1'b0, 2'd0, 11'd0);
        for (int f = 0; f < 32; f++) begin
            frame(1'b0, 2'd0, 11'd0);
            px(52, 0, 4'h3);
        end

        wr(2'd0, 11'd1999);
        frame(1'b0, 2'd0, 11'd0);
        for (int r = 422; r <= 441; r++) begin
            px(r, 632, 4'h6);
            px(r, 639, 4'h6);
            px(r, 640, 4'h6);
        end
        px(436, 631, 4'h6);

        wr(2'd0, 11'd2000);
        chk_rd("rd_pos2000", 2'd0, 11'd2000);
        frame(1'b0, 2'd0, 11'd0);
        for (int r = 424; r <= 441; r++) begin
            px(r, 632, 4'h6);
            px(r, 639, 4'h6);
        end
        px(52, 0, 4'h6);

        wr(2'd0, 11'd0);
        wr(2'd1, 11'd21);
        chk_rd("rd_shape21", 2'd1, 11'd21);
        frame(1'b0, 2'd0, 11'd0);
        for (int r = 40; r <= 55; r++)
            px(r, 0, 4'h6);

        wr(2'd1, 11'h03E);
        wr(2'd2, 11'd0);
        frame(1'b0, 2'd0, 11'd0);
        for (int i = 0; i < 200; i++)
            drive(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, 2'd0, 11'd0);

        px(0, 700, 4'h3);
        wr(2'd0, 11'd81);
        wr(2'd2, 11'd3);
        frame(1'b0, 2'd0, 11'd0);
        px(68, 8, 4'h3);
        repeat (3) @(posedge clk);
        #1;
        pix_r = 4'h5; pix_g = 4'h5; pix_b = 4'h5;
        pix_hsync = 1'b0; pix_vsync = 1'b1;
        pix_row = 10'd0; pix_col = 10'd700;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_r", {12'b0, vga_r}, 16'h5);
        reset_n = 1'b0;
        #1;
        chk("arst_r", {12'b0, vga_r}, 16'h0);
        chk("arst_g", {12'b0, vga_g}, 16'h0);
        chk("arst_b", {12'b0, vga_b}, 16'h0);
        chk("arst_hs", {15'b0, vga_hsync}, 16'h1);
        chk("arst_vs", {15'b0, vga_vsync}, 16'h1);
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        chk_rd("rd_pos_arst", 2'd0, 11'd0);
        px(52, 0, 4'h3);
        px(68, 8, 4'h3);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
